adsr_envelope: RTL and testbench
================================

Name: adsr_envelope

Overview:
Downstream amplitude stage for the noise/tone generators. It takes a signed 8-bit sample stream, e.g. noise_out from the noise generator, and applies an attack/decay/sustain/release envelope keyed by a gate input. It outputs the scaled signed 8-bit sample to the mixer/DAC path. The envelope advances on a prescaled tick derived from the system clock.

Parameters:
TICK_DIV, 4, clk cycles per envelope tick (must be ≥1)
LEVEL_W, 8, envelope level width (fixed at 8 for this revision)

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
wave_in  input  8  signed input sample
gate  input  1  note on (1) / note off (0)
attack_step  input  8  level increment per tick in ATTACK
decay_step  input  8  level decrement per tick in DECAY
sustain_level  input  8  hold level in SUSTAIN
release_step  input  8  level decrement per tick in RELEASE
wave_out  output  8  signed scaled sample, registered
level  output  8  current envelope level, unsigned
state  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
busy  output  1  state != IDLE

Behaviour:
- Reset is synchronous and active-low. Clock and reset ports are clk and rst_n.
- Sampled with rst_n=0 at posedge: state=IDLE, level=0, wave_out=0, busy=0, prescaler=0, gate_q=0.
- Reset overrides everything, including in mid-envelope.
- Prescaler: free-running 0..TICK_DIV-1, never cleared by gate. tick=1 in the cycle where count==TICK_DIV-1.
- Gate edge detection: gate_q holds the registered gate. rise = gate & ~gate_q; fall = ~gate & gate_q.
- Priority per cycle: reset > gate edge > tick. On a gate-edge cycle the level holds and only the state changes.
- IDLE: level=0. On rise, go to ATTACK.
- ATTACK, on tick:
  - If level+attack_step ≥ 255 (9-bit sum): level=255, go to DECAY.
  - Else level += attack_step.
  - With attack_step=0 the level holds indefinitely.
- DECAY, on tick:
  - If level-decay_step ≤ sustain_level (9-bit signed compare, no underflow): level=sustain_level, go to SUSTAIN.
  - Else level -= decay_step.
- SUSTAIN: level tracks sustain_level every cycle, independent of tick.
- Fall in ATTACK, DECAY or SUSTAIN: go to RELEASE from the current level.
- RELEASE, on tick:
  - If level ≤ release_step: level=0, go to IDLE.
  - Else level -= release_step.
- Rise in RELEASE: go to ATTACK from the current level (retrigger, no reset to 0).
- Output arithmetic: product = wave_in (signed) × {1'b0, level} (signed 9-bit), 17-bit signed. wave_out = product >>> 8 (arithmetic, floor).
  - wave_out registers 1 cycle after wave_in and level.
  - Range: -128×255 → -128; 127×255 → 126; -1×1 → -1.
  - level=0 gives exactly 0.
- Input step/sustain values are sampled live each cycle and are not latched.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles while gate=1 and wave_in=100 → wave_out=0, level=0, state=0, busy=0. Release rst_n with gate still 1 → no rise (gate_q was 0 after reset, so rise fires one cycle after release); verify state=1 the next cycle.
- Full ADSR, TICK_DIV=4, wave_in=100, attack=64, decay=32, sustain=128, release=50:
  - Attack ticks give levels 64, 128, 192, 255, then DECAY.
  - Decay ticks give 223, 191, 159, then 128 and SUSTAIN; wave_out=50.
  - Drop gate → RELEASE ticks give 78, 28, 0, then IDLE with busy=0.
  - Each level step lands exactly 4 cycles apart.
- Retrigger: in RELEASE at level 78, raise gate → state=1, next ticks give 142, 206, 255, then DECAY.
- Scaling extremes: level=255 with wave_in=-128/127/0 → wave_out=-128/126/0 one cycle later. level=1 with wave_in=-1 → -1. level=0 with any wave_in → 0.
- Edge/tick collision: gate falls in the same cycle as a tick during ATTACK at level 128 → state=RELEASE, level stays 128. The first release step occurs on the next tick.
- Mid-operation reset: assert rst_n=0 for 1 cycle in SUSTAIN → next posedge gives state=0, level=0, wave_out=0, prescaler restarts at 0 (first tick 4 cycles after reset release).

Source files
------------

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: scales a signed 8-bit sample stream by an envelope
// level that advances on a prescaled tick and is keyed by the gate input.
module adsr_envelope #(
   parameter int TICK_DIV = 4,
   parameter int LEVEL_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         wave_in,
   input  logic               gate,
   input  logic [LEVEL_W-1:0] attack_step,
   input  logic [LEVEL_W-1:0] decay_step,
   input  logic [LEVEL_W-1:0] sustain_level,
   input  logic [LEVEL_W-1:0] release_step,
   output logic [7:0]         wave_out,
   output logic [LEVEL_W-1:0] level,
   output logic [2:0]         state,
   output logic               busy
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ATTACK  = 3'd1,
      S_DECAY   = 3'd2,
      S_SUSTAIN = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   state_t                   state_q, state_d;
   logic [LEVEL_W-1:0]       level_q, level_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     gate_q, gate_d;
   logic [7:0]               wave_out_q, wave_out_d;

   logic                     tick, rise, fall;
   logic [LEVEL_W:0]         att_sum;
   logic signed [LEVEL_W:0]  dec_diff;
   logic signed [LEVEL_W+8:0] product;

   always_comb begin
      tick     = (cnt_q == CNT_W'(TICK_DIV - 1));
      cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
      gate_d   = gate;
      rise     = gate & ~gate_q;
      fall     = ~gate & gate_q;
      att_sum  = {1'b0, level_q} + {1'b0, attack_step};
      dec_diff = $signed({1'b0, level_q}) - $signed({1'b0, decay_step});
      // Level is zero-extended so the multiply stays signed without flipping 255 to -1.
      product    = $signed(wave_in) * $signed({1'b0, level_q});
      wave_out_d = product[LEVEL_W+7:LEVEL_W];
   end

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      if (rise || fall) begin
         // Edge cycles only move the state; the level is frozen for this cycle.
         if (rise && (state_q == S_IDLE || state_q == S_RELEASE))
            state_d = S_ATTACK;
         else if (fall && (state_q == S_ATTACK || state_q == S_DECAY || state_q == S_SUSTAIN))
            state_d = S_RELEASE;
      end else begin
         case (state_q)
            S_IDLE: level_d = '0;
            S_ATTACK: if (tick) begin
               if (att_sum >= {1'b0, {LEVEL_W{1'b1}}}) begin
                  level_d = {LEVEL_W{1'b1}};
                  state_d = S_DECAY;
               end else begin
                  level_d = att_sum[LEVEL_W-1:0];
               end
            end
            S_DECAY: if (tick) begin
               if (dec_diff <= $signed({1'b0, sustain_level})) begin
                  level_d = sustain_level;
                  state_d = S_SUSTAIN;
               end else begin
                  level_d = dec_diff[LEVEL_W-1:0];
               end
            end
            S_SUSTAIN: level_d = sustain_level;
            S_RELEASE: if (tick) begin
               if (level_q <= release_step) begin
                  level_d = '0;
                  state_d = S_IDLE;
               end else begin
                  level_d = level_q - release_step;
               end
            end
            default: begin
               level_d = '0;
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         level_q    <= '0;
         cnt_q      <= '0;
         gate_q     <= 1'b0;
         wave_out_q <= '0;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         cnt_q      <= cnt_d;
         gate_q     <= gate_d;
         wave_out_q <= wave_out_d;
      end
   end

   assign wave_out = wave_out_q;
   assign level    = level_q;
   assign state    = state_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: directed envelope scenarios plus randomized traffic,
// all checked cycle by cycle against an integer reference model.
module tb_adsr_envelope;

   localparam int TICK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] wave_in;
   logic       gate;
   logic [7:0] attack_step, decay_step, sustain_level, release_step;
   logic [7:0] wave_out;
   logic [7:0] level;
   logic [2:0] state;
   logic       busy;

   adsr_envelope #(.TICK_DIV(TICK_DIV), .LEVEL_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .wave_in(wave_in), .gate(gate),
      .attack_step(attack_step), .decay_step(decay_step),
      .sustain_level(sustain_level), .release_step(release_step),
      .wave_out(wave_out), .level(level), .state(state), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
   int m_st = 0, m_lv = 0, m_wo = 0, m_cnt = 0, m_gq = 0;
   int cyc_n = 0;
   int prev_lv = 0;
   int lv_q[$];
   int t_q[$];
   int exp_q[$];

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_step();
      int w, p, t, r, f;
      if (!rst_n) begin
         m_st = 0; m_lv = 0; m_wo = 0; m_cnt = 0; m_gq = 0;
      end else begin
         w = int'($signed(wave_in));
         p = w * m_lv;
         m_wo = (p >= 0) ? p / 256 : -((-p + 255) / 256);
         t = (m_cnt == TICK_DIV - 1);
         r = (gate && !m_gq);
         f = (!gate && m_gq);
         if (r || f) begin
            if (r && (m_st == 0 || m_st == 4)) m_st = 1;
            else if (f && m_st >= 1 && m_st <= 3) m_st = 4;
         end else begin
            case (m_st)
               0: m_lv = 0;
               1: if (t) begin
                     if (m_lv + attack_step >= 255) begin m_lv = 255; m_st = 2; end
                     else m_lv = m_lv + attack_step;
                  end
               2: if (t) begin
                     if (m_lv - int'(decay_step) <= int'(sustain_level)) begin
                        m_lv = sustain_level; m_st = 3;
                     end else m_lv = m_lv - decay_step;
                  end
               3: m_lv = sustain_level;
               default: if (t) begin
                     if (m_lv <= release_step) begin m_lv = 0; m_st = 0; end
                     else m_lv = m_lv - release_step;
                  end
            endcase
         end
         m_cnt = (m_cnt + 1) % TICK_DIV;
         m_gq = gate;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      cyc_n++;
      chk("state", int'(state), m_st);
      chk("level", int'(level), m_lv);
      chk("busy", int'(busy), int'(m_st != 0));
      chk("wave_out", int'($signed(wave_out)), m_wo);
      if (int'(level) != prev_lv) begin
         lv_q.push_back(int'(level));
         t_q.push_back(cyc_n);
      end
      prev_lv = int'(level);
   endtask

   task automatic wait_state(input string tag, input int s, input int bound);
      for (int i = 0; i < bound && int'(state) != s; i++) cyc();
      chk(tag, int'(state), s);
   endtask

   task automatic clr_hist();
      lv_q.delete();
      t_q.delete();
   endtask

   task automatic check_seq(input string tag);
      chk({tag, "_len"}, lv_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < lv_q.size(); i++) begin
         chk({tag, "_lv"}, lv_q[i], exp_q[i]);
         if (i > 0) chk({tag, "_gap"}, t_q[i] - t_q[i-1], TICK_DIV);
      end
   endtask

   initial begin
      int n;
      attack_step = 64; decay_step = 32; sustain_level = 128; release_step = 50;
      gate = 1'b1; wave_in = 8'd100; rst_n = 1'b0;
      cyc(); cyc();
      chk("rst_wo", int'(wave_out), 0);
      chk("rst_state", int'(state), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_busy", int'(busy), 0);
      rst_n = 1'b1;
      cyc();
      chk("rise_after_rst", int'(state), 1);

      // full attack/decay into sustain
      clr_hist();
      wait_state("adsr_sustain", 3, 100);
      exp_q = '{64, 128, 192, 255, 223, 191, 159, 128};
      check_seq("adsr");
      cyc();
      chk("sustain_wo", int'($signed(wave_out)), 50);

      gate = 1'b0;
      clr_hist();
      wait_state("release_idle", 0, 100);
      exp_q = '{78, 28, 0};
      check_seq("release");
      chk("idle_busy", int'(busy), 0);

      // retrigger during release
      gate = 1'b1;
      wait_state("retrig_sus", 3, 100);
      gate = 1'b0;
      for (int i = 0; i < 30 && int'(level) != 78; i++) cyc();
      chk("retrig_at78", int'(level), 78);
      gate = 1'b1;
      clr_hist();
      cyc();
      chk("retrig_state", int'(state), 1);
      chk("retrig_level", int'(level), 78);
      wait_state("retrig_decay", 2, 100);
      exp_q = '{142, 206, 255};
      check_seq("retrig");

      // gate fall coinciding with a tick in attack at level 128
      gate = 1'b0;
      wait_state("coll_idle", 0, 100);
      gate = 1'b1;
      cyc();
      for (int i = 0; i < 40 && !(m_st == 1 && m_lv == 128 && m_cnt == TICK_DIV - 1); i++) cyc();
      chk("coll_setup_lv", int'(level), 128);
      gate = 1'b0;
      cyc();
      chk("coll_state", int'(state), 4);
      chk("coll_level", int'(level), 128);
      clr_hist();
      n = 0;
      for (int i = 0; i < 12 && lv_q.size() == 0; i++) begin cyc(); n++; end
      chk("coll_gap", n, TICK_DIV);
      chk("coll_step", (lv_q.size() > 0) ? lv_q[0] : -1, 78);

      // scaling extremes via sustain tracking
      attack_step = 255; decay_step = 0; sustain_level = 255;
      gate = 1'b1;
      wait_state("ext_sus", 3, 60);
      chk("ext_lv255", int'(level), 255);
      wave_in = 8'h80; cyc();
      chk("ext_m128", int'($signed(wave_out)), -128);
      wave_in = 8'h7F; cyc();
      chk("ext_p127", int'($signed(wave_out)), 126);
      wave_in = 8'h00; cyc();
      chk("ext_zero", int'($signed(wave_out)), 0);
      sustain_level = 1; cyc();
      wave_in = 8'hFF; cyc();
      chk("ext_m1", int'($signed(wave_out)), -1);
      sustain_level = 0; cyc();
      wave_in = 8'($urandom_range(1, 255)); cyc();
      chk("ext_lv0", int'($signed(wave_out)), 0);

      // reset in the middle of sustain; prescaler must restart
      sustain_level = 128; wave_in = 8'd100; cyc();
      rst_n = 1'b0; cyc();
      chk("mrst_state", int'(state), 0);
      chk("mrst_level", int'(level), 0);
      chk("mrst_wo", int'(wave_out), 0);
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 20 && int'(level) == 0; i++) begin cyc(); n++; end
      chk("mrst_first_tick", n, TICK_DIV);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) gate = ~gate;
         if ($urandom_range(0, 49) == 0) begin
            attack_step   = 8'($urandom_range(0, 90));
            decay_step    = 8'($urandom_range(0, 90));
            sustain_level = 8'($urandom_range(0, 255));
            release_step  = 8'($urandom_range(0, 90));
         end
         wave_in = 8'($urandom);
         rst_n = ($urandom_range(0, 399) != 0);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
